photo_transition_sequencer: RTL
===============================

Name: photo_transition_sequencer

Overview:
- Sequences the split/merge slideshow transition for the 320x240 frame buffer shown 2x-scaled on the 640x480 VGA output.
- Owns the animation state machine and its offset counters.
- Maps VGA (h_cnt, v_cnt) to a frame-buffer read address plus a blank flag for the pixel mux.
- Sits between the VGA controller / button one-pulse logic and the block-RAM read port.

Parameters:
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in pixels
- SPLIT_MAX, 160, final split offset (IMG_W/2)
- MERGE_MAX, 120, final merge offset (IMG_H/2)
- ADDR_W, 17, frame-buffer address width

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- step_en  in  1  one-cycle pulse per animation step
- toggle  in  1  one-cycle debounced button pulse; flips run/pause
- valid  in  1  VGA active-video flag
- h_cnt  in  10  VGA column, 0..639
- v_cnt  in  10  VGA row, 0..479
- pixel_addr  out  ADDR_W  frame-buffer read address (registered)
- blank  out  1  1 = drive black (registered)
- state  out  2  IDLE=00, SPLIT=01, MERGE=10
- running  out  1  run flag
- loops  out  8  completed split+merge cycles, wraps at 255

Behaviour:
- Reset (synchronous; applies mid-transition too): state=IDLE, split_off=0, merge_off=0, running=0, loops=0, pixel_addr=0, blank=1.
- running toggles on each toggle pulse.
- step_en samples the pre-toggle value of running: when toggle and step_en coincide, that step uses the old run value.
- Counters and state change only on step_en with running=1. Otherwise everything holds (pause).
- IDLE: on step -> SPLIT, split_off=0.
- SPLIT: on step, if split_off==SPLIT_MAX -> MERGE with merge_off=0; else split_off+1.
- MERGE: on step, if merge_off==MERGE_MAX -> SPLIT with split_off=0 and loops+1; else merge_off+1.
- Address map (x=h_cnt>>1, y=v_cnt>>1):
  - IDLE: src=(x,y), blank=0.
  - SPLIT, x<160: sx=x+split_off; blank if sx>=160.
  - SPLIT, x>=160: sx=x-split_off; blank if sx<160. Compute the compare without underflow.
  - MERGE: d=MERGE_MAX-merge_off. y<120: sy=y+d, blank if sy>=120. y>=120: sy=y-d, blank if sy<120.
- Continuity: split_off=160 and merge_off=0 both give a fully black frame.
- pixel_addr = sy*IMG_W + sx when not blanked; 0 when blanked.
- valid=0 forces blank=1 and pixel_addr=0.
- Latency: one clk from h_cnt/v_cnt/valid to pixel_addr/blank. The state used is the value registered at that edge.
- Address arithmetic is at least 18 bits internally, truncated to ADDR_W; the maximum legal value is 76799.

Optional Feature:
- Macro: SEQ_ONESHOT_EN.
- Defined: when MERGE completes, go to IDLE, clear running, increment loops. One press gives one transition.
- Undefined: MERGE loops back to SPLIT as described above.

Decomposition:
- Package photo_seq_pkg: state encodings ST_IDLE/ST_SPLIT/ST_MERGE; IMG_W, IMG_H, SPLIT_MAX, MERGE_MAX constants.
- Sub-module photo_addr_map: pure mapping (x, y, state, split_off, merge_off) -> (addr, blank). The top level registers its outputs.

Test Plan:
- Reset, then toggle, then 1 step -> state=01, split_off=0. At h_cnt=0, v_cnt=0: pixel_addr=0, blank=0.
- SPLIT with split_off=10, h_cnt=300 (x=150), v_cnt=0 -> blank=1. h_cnt=100 (x=50) -> pixel_addr=60, blank=0.
- 161 steps in SPLIT -> state=10, merge_off=0; any valid pixel gives blank=1.
- MERGE with merge_off=120, h_cnt=2, v_cnt=300 -> pixel_addr=150*320+1=48001, blank=0. After the next step: state=01, loops=1.
- Toggle mid-SPLIT -> running=0; 5 step pulses leave split_off unchanged. Toggle and step_en in the same cycle -> no advance.
- rst asserted during MERGE -> next cycle state=00, running=0, loops=0, blank=1. With SEQ_ONESHOT_EN, completing MERGE -> state=00, running=0.

Source files
------------

// File: rtl/photo_seq_pkg.sv
// Shared constants and state encodings for the split/merge slideshow sequencer.
package photo_seq_pkg;

  localparam int unsigned IMG_W     = 320;
  localparam int unsigned IMG_H     = 240;
  localparam int unsigned SPLIT_MAX = IMG_W / 2;
  localparam int unsigned MERGE_MAX = IMG_H / 2;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 2'b00;
  localparam seq_state_t ST_SPLIT = 2'b01;
  localparam seq_state_t ST_MERGE = 2'b10;

endpackage

// File: rtl/photo_addr_map.sv
// Pure combinational map from half-resolution screen position and animation
// state to a frame-buffer read address plus a blank flag.
module photo_addr_map
  import photo_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic [8:0]        x,
  input  logic [8:0]        y,
  input  seq_state_t        state,
  input  logic [7:0]        split_off,
  input  logic [7:0]        merge_off,
  output logic [ADDR_W-1:0] addr,
  output logic              blank
);

  localparam logic [9:0]  HALF_W = 10'(SPLIT_MAX);
  localparam logic [9:0]  HALF_H = 10'(MERGE_MAX);
  localparam logic [17:0] ROW    = 18'(IMG_W);

  logic [9:0]  xe, ye, so, d, sx, sy;
  logic [17:0] full;

  always_comb begin
    xe    = {1'b0, x};
    ye    = {1'b0, y};
    so    = {2'b00, split_off};
    d     = HALF_H - {2'b00, merge_off};
    sx    = xe;
    sy    = ye;
    blank = 1'b0;
    case (state)
      ST_SPLIT: begin
        if (xe < HALF_W) begin
          sx    = xe + so;
          blank = (sx >= HALF_W);
        end else begin
          // compare against HALF_W+offset so the subtraction never wraps
          blank = (xe < HALF_W + so);
          sx    = xe - so;
        end
      end
      ST_MERGE: begin
        if (ye < HALF_H) begin
          sy    = ye + d;
          blank = (sy >= HALF_H);
        end else begin
          blank = (ye < HALF_H + d);
          sy    = ye - d;
        end
      end
      default: ;
    endcase
    full = ({8'b0, sy} * ROW) + {8'b0, sx};
    addr = blank ? '0 : ADDR_W'(full);
  end

endmodule

// File: rtl/photo_transition_sequencer.sv
// Split/merge slideshow sequencer: animation FSM, offset counters and
// registered VGA-to-frame-buffer address mapping. Option: SEQ_ONESHOT_EN.
module photo_transition_sequencer
  import photo_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic              toggle,
  input  logic              valid,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              blank,
  output logic [1:0]        state,
  output logic              running,
  output logic [7:0]        loops
);

  logic [7:0]        split_off;
  logic [7:0]        merge_off;
  logic [8:0]        px, py;
  logic [ADDR_W-1:0] map_addr;
  logic              map_blank;
  logic              adv;

  assign px  = 9'(h_cnt >> 1);
  assign py  = 9'(v_cnt >> 1);
  // step uses the run flag as it stood before any coincident toggle
  assign adv = step_en & running;

  photo_addr_map #(.ADDR_W(ADDR_W)) u_map (
    .x         (px),
    .y         (py),
    .state     (state),
    .split_off (split_off),
    .merge_off (merge_off),
    .addr      (map_addr),
    .blank     (map_blank)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      split_off  <= '0;
      merge_off  <= '0;
      running    <= 1'b0;
      loops      <= '0;
      pixel_addr <= '0;
      blank      <= 1'b1;
    end else begin
      running <= running ^ toggle;

      if (valid) begin
        pixel_addr <= map_addr;
        blank      <= map_blank;
      end else begin
        pixel_addr <= '0;
        blank      <= 1'b1;
      end

      if (adv) begin
        case (state)
          ST_IDLE: begin
            state     <= ST_SPLIT;
            split_off <= '0;
          end
          ST_SPLIT: begin
            if (split_off == 8'(SPLIT_MAX)) begin
              state     <= ST_MERGE;
              merge_off <= '0;
            end else begin
              split_off <= split_off + 8'd1;
            end
          end
          ST_MERGE: begin
            if (merge_off == 8'(MERGE_MAX)) begin
              loops <= loops + 8'd1;
`ifdef SEQ_ONESHOT_EN
              state   <= ST_IDLE;
              running <= 1'b0;
`else
              state     <= ST_SPLIT;
              split_off <= '0;
`endif
            end else begin
              merge_off <= merge_off + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
